rob_wb_arbiter: RTL and testbench

- Arbitrates completion requests from NUM_REQ execution units onto WB_PORTS registered ROB writeback channels.
- Each output channel carries en, bank_addr, rob_addr and phys_rd, and feeds the ROB completion and physical-register ready logic.
- Round-robin priority gives every unit bounded wait; losers are back-pressured through valid/ready.
- Sits between the functional-unit result stage and the ROB.

---
 rtl/rob_wb_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_rob_wb_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rob_wb_arbiter.sv
// +----------------------------------------------------------------------------+
// | rob_wb_arbiter                                                             |
// | Round-robin arbiter merging NUM_REQ unit completions onto WB_PORTS         |
// | registered ROB writeback channels.                                         |
// | Optional statistics outputs are enabled by macro ROB_WB_ARB_STATS_EN.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rob_wb_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int WB_PORTS        = 2,
    parameter int ROB_ADDR_WIDTH  = 6,
    parameter int BANK_ADDR_WIDTH = 1,
    parameter int PREG_WIDTH      = 7
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ*ROB_ADDR_WIDTH-1:0]   req_rob_addr,
    input  logic [NUM_REQ*BANK_ADDR_WIDTH-1:0]  req_bank_addr,
    input  logic [NUM_REQ*PREG_WIDTH-1:0]       req_phys_rd,
    output logic [WB_PORTS-1:0]                 wb_en,
    output logic [WB_PORTS*ROB_ADDR_WIDTH-1:0]  wb_rob_addr,
    output logic [WB_PORTS*BANK_ADDR_WIDTH-1:0] wb_bank_addr,
    output logic [WB_PORTS*PREG_WIDTH-1:0]      wb_phys_rd
`ifdef ROB_WB_ARB_STATS_EN
    ,
    output logic [31:0]                         conflict_cnt,
    output logic [7:0]                          starve_max
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SUM_W = PTR_W + 1;
    localparam int CNT_W = $clog2(WB_PORTS + 1);

    logic [PTR_W-1:0]            rr_ptr_q;
    logic [PTR_W-1:0]            rr_ptr_d;
    logic [NUM_REQ-1:0]          grant;
    logic [CNT_W-1:0]            chan_of [NUM_REQ];
    logic [CNT_W-1:0]            cnt;
    logic [PTR_W-1:0]            last_idx;
    logic [PTR_W-1:0]            idx;
    logic [SUM_W-1:0]            sum;

    logic [WB_PORTS-1:0]                 wb_en_q,        wb_en_d;
    logic [WB_PORTS*ROB_ADDR_WIDTH-1:0]  wb_rob_addr_q,  wb_rob_addr_d;
    logic [WB_PORTS*BANK_ADDR_WIDTH-1:0] wb_bank_addr_q, wb_bank_addr_d;
    logic [WB_PORTS*PREG_WIDTH-1:0]      wb_phys_rd_q,   wb_phys_rd_d;

    // Rotating scan from rr_ptr; the k-th valid unit found is bound to channel k.
    always_comb begin : p_grant
        grant    = '0;
        chan_of  = '{default: '0};
        cnt      = '0;
        last_idx = rr_ptr_q;
        idx      = '0;
        sum      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rr_ptr_q} + SUM_W'(i);
            if (sum >= SUM_W'(NUM_REQ)) begin
                sum = sum - SUM_W'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (req_valid[idx] && (cnt < CNT_W'(WB_PORTS))) begin
                grant[idx]   = 1'b1;
                chan_of[idx] = cnt;
                cnt          = cnt + CNT_W'(1);
                last_idx     = idx;
            end
        end
        if (flush || !rst_n) begin
            grant = '0;
        end
    end

    assign req_ready = grant;

    always_comb begin : p_rr_next
        rr_ptr_d = rr_ptr_q;
        if (|grant) begin
            rr_ptr_d = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + PTR_W'(1);
        end
    end

    // Ungranted channels keep their previous payload; only wb_en drops.
    always_comb begin : p_wb_next
        wb_en_d        = '0;
        wb_rob_addr_d  = wb_rob_addr_q;
        wb_bank_addr_d = wb_bank_addr_q;
        wb_phys_rd_d   = wb_phys_rd_q;
        for (int k = 0; k < WB_PORTS; k++) begin
            for (int u = 0; u < NUM_REQ; u++) begin
                if (grant[u] && (chan_of[u] == CNT_W'(k))) begin
                    wb_en_d[k] = 1'b1;
                    wb_rob_addr_d[k*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH] =
                        req_rob_addr[u*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH];
                    wb_bank_addr_d[k*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH] =
                        req_bank_addr[u*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH];
                    wb_phys_rd_d[k*PREG_WIDTH +: PREG_WIDTH] =
                        req_phys_rd[u*PREG_WIDTH +: PREG_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_regs
        if (!rst_n) begin
            rr_ptr_q       <= '0;
            wb_en_q        <= '0;
            wb_rob_addr_q  <= '0;
            wb_bank_addr_q <= '0;
            wb_phys_rd_q   <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            wb_en_q        <= wb_en_d;
            wb_rob_addr_q  <= wb_rob_addr_d;
            wb_bank_addr_q <= wb_bank_addr_d;
            wb_phys_rd_q   <= wb_phys_rd_d;
        end
    end

    assign wb_en        = wb_en_q;
    assign wb_rob_addr  = wb_rob_addr_q;
    assign wb_bank_addr = wb_bank_addr_q;
    assign wb_phys_rd   = wb_phys_rd_q;

`ifdef ROB_WB_ARB_STATS_EN
    localparam int VC_W = $clog2(NUM_REQ + 1);

    logic [31:0]     conflict_q, conflict_d;
    logic [7:0]      starve_max_q, starve_max_d;
    logic [7:0]      starve_q [NUM_REQ];
    logic [7:0]      starve_d [NUM_REQ];
    logic [VC_W-1:0] valid_cnt;

    always_comb begin : p_stats_next
        valid_cnt    = '0;
        conflict_d   = conflict_q;
        starve_max_d = starve_max_q;
        starve_d     = '{default: '0};
        for (int u = 0; u < NUM_REQ; u++) begin
            valid_cnt = valid_cnt + VC_W'(req_valid[u]);
            if (req_valid[u] && !req_ready[u]) begin
                starve_d[u] = (starve_q[u] == 8'hFF) ? 8'hFF : starve_q[u] + 8'd1;
            end
            if (starve_d[u] > starve_max_d) begin
                starve_max_d = starve_d[u];
            end
        end
        if (!flush && (valid_cnt > VC_W'(WB_PORTS)) && (conflict_q != 32'hFFFF_FFFF)) begin
            conflict_d = conflict_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_stats_regs
        if (!rst_n) begin
            conflict_q   <= '0;
            starve_max_q <= '0;
            for (int u = 0; u < NUM_REQ; u++) begin
                starve_q[u] <= '0;
            end
        end else begin
            conflict_q   <= conflict_d;
            starve_max_q <= starve_max_d;
            for (int u = 0; u < NUM_REQ; u++) begin
                starve_q[u] <= starve_d[u];
            end
        end
    end

    assign conflict_cnt = conflict_q;
    assign starve_max   = starve_max_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rob_wb_arbiter.sv
// Directed bench for rob_wb_arbiter (NUM_REQ=4, WB_PORTS=2, 6/1/7-bit fields).
`default_nettype none

module tb_rob_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [23:0] req_rob_addr;
    logic [3:0]  req_bank_addr;
    logic [27:0] req_phys_rd;
    logic [1:0]  wb_en;
    logic [11:0] wb_rob_addr;
    logic [1:0]  wb_bank_addr;
    logic [13:0] wb_phys_rd;

    int total = 0;
    int bad   = 0;

    rob_wb_arbiter #(
        .NUM_REQ(4), .WB_PORTS(2), .ROB_ADDR_WIDTH(6), .BANK_ADDR_WIDTH(1), .PREG_WIDTH(7)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rob_addr(req_rob_addr), .req_bank_addr(req_bank_addr), .req_phys_rd(req_phys_rd),
        .wb_en(wb_en), .wb_rob_addr(wb_rob_addr), .wb_bank_addr(wb_bank_addr), .wb_phys_rd(wb_phys_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       flush;
        logic [3:0] valid;
        logic [3:0] exp_ready;
        logic [1:0] exp_en;
        logic [5:0] exp_ch0;
        logic [5:0] exp_ch1;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A unit left waiting must present identical data on the next cycle.
    logic [3:0]  pend_q = '0;
    logic [23:0] rob_q  = '0;
    always @(posedge clk) begin
        for (int u = 0; u < 4; u++) begin
            if (rst_n && pend_q[u]) begin
                assert (req_rob_addr[u*6 +: 6] == rob_q[u*6 +: 6])
                    else $error("FAIL protocol unit %0d data changed while stalled", u);
            end
        end
        pend_q <= req_valid & ~req_ready;
        rob_q  <= req_rob_addr;
    end

    int last_g[4];
    int gcount[4];

    initial begin
        // unit u -> rob {23,22,5,20}[u], bank {1,0,1,0}[u], preg {43,42,12,40}[u]
        req_rob_addr  = {6'd23, 6'd22, 6'd5, 6'd20};
        req_bank_addr = 4'b1010;
        req_phys_rd   = {7'd43, 7'd42, 7'd12, 7'd40};
        rst_n = 1'b0;
        flush = 1'b0;
        req_valid = 4'b0000;

        for (int i = 0; i < 5; i++) vecs[i] = '{1'b0, 4'b0000, 4'b0000, 2'b00, 6'd0, 6'd0};
        vecs[5]  = '{1'b0, 4'b0010, 4'b0010, 2'b01, 6'd5,  6'd0};
        vecs[6]  = '{1'b0, 4'b0000, 4'b0000, 2'b00, 6'd5,  6'd0};
        vecs[7]  = '{1'b0, 4'b1000, 4'b1000, 2'b01, 6'd23, 6'd0};
        vecs[8]  = '{1'b0, 4'b1111, 4'b0011, 2'b11, 6'd20, 6'd5};
        vecs[9]  = '{1'b0, 4'b1111, 4'b1100, 2'b11, 6'd22, 6'd23};
        vecs[10] = '{1'b0, 4'b1111, 4'b0011, 2'b11, 6'd20, 6'd5};
        vecs[11] = '{1'b0, 4'b1111, 4'b1100, 2'b11, 6'd22, 6'd23};
        vecs[12] = '{1'b0, 4'b0100, 4'b0100, 2'b01, 6'd22, 6'd23};
        vecs[13] = '{1'b0, 4'b1001, 4'b1001, 2'b11, 6'd23, 6'd20};
        vecs[14] = '{1'b1, 4'b0111, 4'b0000, 2'b00, 6'd23, 6'd20};
        vecs[15] = '{1'b0, 4'b0111, 4'b0110, 2'b11, 6'd5,  6'd22};
        vecs[16] = '{1'b0, 4'b0111, 4'b0011, 2'b11, 6'd20, 6'd5};
        vecs[17] = '{1'b0, 4'b0111, 4'b0101, 2'b11, 6'd22, 6'd20};
        vecs[18] = '{1'b1, 4'b1111, 4'b0000, 2'b00, 6'd22, 6'd20};
        vecs[19] = '{1'b0, 4'b0000, 4'b0000, 2'b00, 6'd22, 6'd20};

        // Reset state
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        check("ready_in_reset", 32'(req_ready), 32'h0);
        check("wb_en_in_reset", 32'(wb_en), 32'h0);
        check("wb_rob_in_reset", 32'(wb_rob_addr), 32'h0);
        @(negedge clk);
        req_valid = 4'b0000;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            flush     = vecs[i].flush;
            req_valid = vecs[i].valid;
            #1;
            check($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_wb_en", i), 32'(wb_en), 32'(vecs[i].exp_en));
            check($sformatf("v%0d_ch0_rob", i), 32'(wb_rob_addr[5:0]), 32'(vecs[i].exp_ch0));
            check($sformatf("v%0d_ch1_rob", i), 32'(wb_rob_addr[11:6]), 32'(vecs[i].exp_ch1));
            if (i == 5) begin
                check("v5_ch0_bank", 32'(wb_bank_addr[0]), 32'h1);
                check("v5_ch0_preg", 32'(wb_phys_rd[6:0]), 32'd12);
            end
        end

        // Fairness: rr_ptr is 1 here, so grants alternate 0110 / 1001.
        for (int u = 0; u < 4; u++) begin
            last_g[u] = 0;
            gcount[u] = 0;
        end
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            flush = 1'b0;
            req_valid = 4'b1111;
            #1;
            check($sformatf("fair_c%0d_ready", c), 32'(req_ready),
                  (c % 2 == 1) ? 32'h6 : 32'h9);
            for (int u = 0; u < 4; u++) begin
                if (req_ready[u]) begin
                    if (c - last_g[u] > 2) begin
                        bad++;
                        $display("FAIL fair_gap unit %0d: gap %0d limit 2", u, c - last_g[u]);
                    end
                    last_g[u] = c;
                    gcount[u]++;
                end
            end
        end
        for (int u = 0; u < 4; u++) check($sformatf("fair_count_u%0d", u), 32'(gcount[u]), 32'd4);

        // Mid-run async reset clears outputs without a clock edge.
        @(posedge clk);
        #2;
        check("pre_reset_wb_en", 32'(wb_en), 32'h3);
        rst_n = 1'b0;
        flush = 1'b1;
        #1;
        check("async_rst_wb_en", 32'(wb_en), 32'h0);
        check("async_rst_wb_rob", 32'(wb_rob_addr), 32'h0);
        check("async_rst_ready", 32'(req_ready), 32'h0);

        // Reset release: rr_ptr back at 0.
        @(negedge clk);
        rst_n = 1'b1;
        flush = 1'b0;
        req_valid = 4'b1111;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'h3);
        @(posedge clk);
        #1;
        check("post_rst_ch0_rob", 32'(wb_rob_addr[5:0]), 32'd20);
        check("post_rst_ch1_rob", 32'(wb_rob_addr[11:6]), 32'd5);
        check("post_rst_ch1_preg", 32'(wb_phys_rd[13:7]), 32'd12);
        @(negedge clk);
        req_valid = 4'b0000;
        @(posedge clk);
        #1;
        check("idle_wb_en", 32'(wb_en), 32'h0);
        check("idle_hold_ch0", 32'(wb_rob_addr[5:0]), 32'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
